// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA pixel-timing master.
// Divides the system clock into a pixel clock-enable. On each pixel step it
// registers raster coordinates, data-enable, syncs and frame/line markers,
// and keeps copies of DE/HS/VS delayed by SYNC_DELAY pixels so they line up
// with the downstream shader pipeline.
// Optional feature macro: VGA_TIMING_TEST_PATTERN_EN (adds oRGB colour bars).
module vga_timing_gen #(
  parameter int CLK_DIV    = 5,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int SYNC_DELAY = 3
) (
  input  logic       iCLK,
  input  logic       iRESETn,
  output logic       oPIX_CE,
  output logic [9:0] oX,
  output logic [9:0] oY,
  output logic       oDE,
  output logic       oHS,
  output logic       oVS,
  output logic       oFRAME_START,
  output logic       oLINE_START,
  output logic       oDE_D,
  output logic       oHS_D,
  output logic       oVS_D,
  output logic [7:0] oFRAME_CNT
`ifdef VGA_TIMING_TEST_PATTERN_EN
  ,
  output logic [7:0] oRGB
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_ON  = (SYNC_POL != 0);
  localparam logic       SYNC_OFF = !SYNC_ON;

  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       step;
  logic       de_c, hs_c, vs_c;

  logic       pix_ce_q;
  logic [9:0] x_q, y_q;
  logic       de_q, hs_q, vs_q;
  logic       fs_q, ls_q;

  // Divider, raster counters and frame counter next-state; decodes of (h, v).
  always_comb begin
    step   = (div_q == DIV_LAST);
    div_d  = step ? 4'd0 : div_q + 4'd1;
    h_d    = h_q;
    v_d    = v_q;
    fcnt_d = fcnt_q;
    if (step) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        if (v_q == V_LAST) begin
          v_d    = 10'd0;
          fcnt_d = fcnt_q + 8'd1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    de_c = (h_q < H_ACT) && (v_q < V_ACT);
    hs_c = ((h_q >= HS_BEG) && (h_q <= HS_END)) ? SYNC_ON : SYNC_OFF;
    vs_c = ((v_q >= VS_BEG) && (v_q <= VS_END)) ? SYNC_ON : SYNC_OFF;
  end

  // Counters advance every clock; outputs load pixel (h, v) only on a step.
  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      div_q    <= 4'd0;
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      fcnt_q   <= 8'd0;
      pix_ce_q <= 1'b0;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      de_q     <= 1'b0;
      hs_q     <= SYNC_OFF;
      vs_q     <= SYNC_OFF;
      fs_q     <= 1'b0;
      ls_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      fcnt_q   <= fcnt_d;
      pix_ce_q <= step;
      if (step) begin
        x_q  <= h_q;
        y_q  <= v_q;
        de_q <= de_c;
        hs_q <= hs_c;
        vs_q <= vs_c;
        fs_q <= (h_q == 10'd0) && (v_q == 10'd0);
        ls_q <= (h_q == 10'd0);
      end
    end
  end

  // The delay line takes the registered outputs, so stage N-1 trails them by
  // exactly N pixel steps; zero depth degenerates to a straight wire.
  generate
    if (SYNC_DELAY == 0) begin : g_no_dly
      assign oDE_D = de_q;
      assign oHS_D = hs_q;
      assign oVS_D = vs_q;
    end else begin : g_dly
      logic [2:0] dly_q [SYNC_DELAY];

      // Shift {DE, HS, VS} one stage per pixel step.
      always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
          for (int i = 0; i < SYNC_DELAY; i++) dly_q[i] <= {1'b0, SYNC_OFF, SYNC_OFF};
        end else if (step) begin
          dly_q[0] <= {de_q, hs_q, vs_q};
          for (int i = 1; i < SYNC_DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign {oDE_D, oHS_D, oVS_D} = dly_q[SYNC_DELAY-1];
    end
  endgenerate

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar;
  logic [7:0] rgb_c, rgb_q;

  // Eight vertical colour bars across the active width, black in blanking.
  always_comb begin
    bar   = 3'd0;
    rgb_c = 8'h00;
    for (int i = 1; i < 8; i++) begin
      if (h_q >= 10'(i * BAR_W)) bar = 3'(i);
    end
    if (de_c) begin
      case (bar)
        3'd0:    rgb_c = 8'hFF;
        3'd1:    rgb_c = 8'hFC;
        3'd2:    rgb_c = 8'h1F;
        3'd3:    rgb_c = 8'h1C;
        3'd4:    rgb_c = 8'hE3;
        3'd5:    rgb_c = 8'hE0;
        3'd6:    rgb_c = 8'h03;
        default: rgb_c = 8'h00;
      endcase
    end
  end

  // Colour register, aligned with oDE.
  always_ff @(posedge iCLK) begin
    if (!iRESETn)  rgb_q <= 8'h00;
    else if (step) rgb_q <= rgb_c;
  end

  assign oRGB = rgb_q;
`endif

  assign oPIX_CE      = pix_ce_q;
  assign oX           = x_q;
  assign oY           = y_q;
  assign oDE          = de_q;
  assign oHS          = hs_q;
  assign oVS          = vs_q;
  assign oFRAME_START = fs_q;
  assign oLINE_START  = ls_q;
  assign oFRAME_CNT   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two instances with small rasters
// (one active-low sync with 3-pixel delay, one active-high with no delay).
module tb_vga_timing_gen;

  localparam int DIV [2] = '{5, 2};
  localparam int HA  [2] = '{16, 8};
  localparam int HFP [2] = '{2, 1};
  localparam int HSW [2] = '{4, 3};
  localparam int HBP [2] = '{3, 2};
  localparam int VA  [2] = '{6, 4};
  localparam int VFP [2] = '{1, 1};
  localparam int VSW [2] = '{2, 1};
  localparam int VBP [2] = '{2, 2};
  localparam int POL [2] = '{0, 1};
  localparam int DLY [2] = '{3, 0};

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       de, hs, vs, fs, ls, de_d, hs_d, vs_d;
    logic [7:0] fc;
    logic [7:0] rgb;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] ce, de, hs, vs, fs, ls, de_d, hs_d, vs_d;
  logic [9:0] x [2];
  logic [9:0] y [2];
  logic [7:0] fc [2];
  logic [7:0] rgb [2];

  int n_chk = 0;
  int n_err = 0;

  pix_t q0[$];
  pix_t q1[$];

  int         gh [2];
  int         gv [2];
  logic [7:0] gf [2];
  logic [2:0] prev_out [2];
  logic [2:0] hist [2][16];

  vga_timing_gen #(
    .CLK_DIV(DIV[0]), .H_ACTIVE(HA[0]), .H_FP(HFP[0]), .H_SYNC(HSW[0]), .H_BP(HBP[0]),
    .V_ACTIVE(VA[0]), .V_FP(VFP[0]), .V_SYNC(VSW[0]), .V_BP(VBP[0]),
    .SYNC_POL(POL[0]), .SYNC_DELAY(DLY[0])
  ) u_a (
    .iCLK(clk), .iRESETn(rst_n), .oPIX_CE(ce[0]), .oX(x[0]), .oY(y[0]),
    .oDE(de[0]), .oHS(hs[0]), .oVS(vs[0]), .oFRAME_START(fs[0]), .oLINE_START(ls[0]),
    .oDE_D(de_d[0]), .oHS_D(hs_d[0]), .oVS_D(vs_d[0]), .oFRAME_CNT(fc[0])
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , .oRGB(rgb[0])
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(DIV[1]), .H_ACTIVE(HA[1]), .H_FP(HFP[1]), .H_SYNC(HSW[1]), .H_BP(HBP[1]),
    .V_ACTIVE(VA[1]), .V_FP(VFP[1]), .V_SYNC(VSW[1]), .V_BP(VBP[1]),
    .SYNC_POL(POL[1]), .SYNC_DELAY(DLY[1])
  ) u_b (
    .iCLK(clk), .iRESETn(rst_n), .oPIX_CE(ce[1]), .oX(x[1]), .oY(y[1]),
    .oDE(de[1]), .oHS(hs[1]), .oVS(vs[1]), .oFRAME_START(fs[1]), .oLINE_START(ls[1]),
    .oDE_D(de_d[1]), .oHS_D(hs_d[1]), .oVS_D(vs_d[1]), .oFRAME_CNT(fc[1])
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , .oRGB(rgb[1])
`endif
  );

`ifndef VGA_TIMING_TEST_PATTERN_EN
  assign rgb[0] = 8'h00;
  assign rgb[1] = 8'h00;
`endif

  function automatic pix_t sample(input int w);
    pix_t p;
    p.x = x[w];   p.y = y[w];
    p.de = de[w]; p.hs = hs[w]; p.vs = vs[w]; p.fs = fs[w]; p.ls = ls[w];
    p.de_d = de_d[w]; p.hs_d = hs_d[w]; p.vs_d = vs_d[w];
    p.fc = fc[w]; p.rgb = rgb[w];
    return p;
  endfunction

  function automatic pix_t reset_rec(input int w);
    pix_t p;
    logic off;
    off = (POL[w] == 0);
    p = '{x: 10'd0, y: 10'd0, de: 1'b0, hs: off, vs: off, fs: 1'b0, ls: 1'b0,
          de_d: 1'b0, hs_d: off, vs_d: off, fc: 8'd0, rgb: 8'd0};
    return p;
  endfunction

  function automatic logic [7:0] bar_rgb(input int h, input int w);
    logic [7:0] lut [8];
    lut = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    return lut[h / (HA[w] / 8)];
  endfunction

  task automatic check(input string name, input logic ok, input int act, input int req);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic gen_reset(input int w);
    logic off;
    off = (POL[w] == 0);
    gh[w] = 0;
    gv[w] = 0;
    gf[w] = 8'd0;
    prev_out[w] = {1'b0, off, off};
    for (int i = 0; i < 16; i++) hist[w][i] = {1'b0, off, off};
  endtask

  // Push the expected records of the next n pixel steps of instance w.
  task automatic gen_push(input int w, input int n);
    int h, v, ht, vt;
    logic on, dep, hsp, vsp;
    logic [2:0] cur, dd;
    logic [7:0] col;
    pix_t p;
    on = (POL[w] != 0);
    ht = HA[w] + HFP[w] + HSW[w] + HBP[w];
    vt = VA[w] + VFP[w] + VSW[w] + VBP[w];
    for (int k = 0; k < n; k++) begin
      h = gh[w];
      v = gv[w];
      dep = (h < HA[w]) && (v < VA[w]);
      hsp = (h >= HA[w] + HFP[w] && h <= HA[w] + HFP[w] + HSW[w] - 1) ? on : !on;
      vsp = (v >= VA[w] + VFP[w] && v <= VA[w] + VFP[w] + VSW[w] - 1) ? on : !on;
      cur = {dep, hsp, vsp};
      if (DLY[w] == 0) begin
        dd = cur;
      end else begin
        for (int i = DLY[w] - 1; i > 0; i--) hist[w][i] = hist[w][i-1];
        hist[w][0] = prev_out[w];
        dd = hist[w][DLY[w]-1];
      end
      prev_out[w] = cur;
      if (h == ht - 1 && v == vt - 1) gf[w] = gf[w] + 8'd1;
      col = 8'h00;
`ifdef VGA_TIMING_TEST_PATTERN_EN
      if (dep) col = bar_rgb(h, w);
`endif
      p = '{x: 10'(h), y: 10'(v), de: dep, hs: hsp, vs: vsp,
            fs: (h == 0 && v == 0), ls: (h == 0),
            de_d: dd[2], hs_d: dd[1], vs_d: dd[0], fc: gf[w], rgb: col};
      if (w == 0) q0.push_back(p);
      else        q1.push_back(p);
      if (h == ht - 1) begin
        gh[w] = 0;
        gv[w] = (v == vt - 1) ? 0 : v + 1;
      end else begin
        gh[w] = h + 1;
      end
    end
  endtask

  // Monitor: pixel pacing, hold between steps, scoreboard compare on each step.
  task automatic run_monitor(input int w);
    int   since;
    pix_t prev, act, exp;
    logic have;
    since = 0;
    prev  = sample(w);
    forever begin
      @(posedge clk);
      #1;
      act = sample(w);
      if (!rst_n) begin
        since = 0;
        prev  = act;
        continue;
      end
      since++;
      if (!ce[w]) begin
        check($sformatf("hold%0d", w), act === prev, int'(act[31:0]), int'(prev[31:0]));
      end else begin
        check($sformatf("pix_ce_gap%0d", w), since == DIV[w], since, DIV[w]);
        since = 0;
        have  = 1'b0;
        if (w == 0 && q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
        if (w == 1 && q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
        if (have) begin
          n_chk++;
          if (act !== exp) begin
            n_err++;
            $display("FAIL pixel%0d: got %h expected %h at %0t", w, act, exp, $time);
          end
        end
      end
      prev = act;
    end
  endtask

  task automatic wait_empty(input int w, input int max_cyc);
    int n;
    n = 0;
    while (((w == 0) ? q0.size() : q1.size()) > 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    check($sformatf("drain%0d", w), ((w == 0) ? q0.size() : q1.size()) == 0,
          (w == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial run_monitor(0);
  initial run_monitor(1);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_t r;
    gen_reset(0);
    gen_reset(1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      r = reset_rec(w);
      check($sformatf("reset_state%0d", w), sample(w) === r, int'(sample(w)[31:0]), int'(r[31:0]));
      check($sformatf("reset_ce%0d", w), ce[w] === 1'b0, ce[w], 0);
    end

    // Two full frames plus a few pixels on both instances.
    @(negedge clk);
    rst_n = 1'b1;
    gen_push(0, 2 * 275 + 10);
    gen_push(1, 2 * 112 + 6);
    wait_empty(0, 4000);
    wait_empty(1, 100);

    // Run instance A to (19,3), inside its horizontal sync pulse (18..21).
    gen_push(0, 85);
    wait_empty(0, 600);
    check("pre_rst_x", x[0] === 10'd19, x[0], 19);
    check("pre_rst_y", y[0] === 10'd3, y[0], 3);
    check("pre_rst_hs", hs[0] === 1'b0, hs[0], 0);

    // One-cycle reset pulse mid-frame.
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    gen_reset(0);
    gen_reset(1);
    @(posedge clk);
    #1;
    check("rst_hs", hs[0] === 1'b1, hs[0], 1);
    check("rst_hs_d", hs_d[0] === 1'b1, hs_d[0], 1);
    check("rst_fcnt", fc[0] === 8'd0, fc[0], 0);
    r = reset_rec(1);
    check("rst_state1", sample(1) === r, int'(sample(1)[31:0]), int'(r[31:0]));

    // Restart from (0,0) and cover a full frame again.
    @(negedge clk);
    rst_n = 1'b1;
    gen_push(0, 280);
    gen_push(1, 120);
    wait_empty(0, 1600);
    wait_empty(1, 100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
